// File: rtl/act_skew_feeder_if.sv
// Activation-feeder bus: tile control, upstream vector handshake and skewed row outputs.
// Handshake: a vector transfers on a rising clk edge where in_valid && in_ready are both high.
interface act_skew_feeder_if #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int CNT_W  = 16
);
  logic                     start;
  logic [CNT_W-1:0]         num_vec;
  logic                     weight_busy;
  logic                     in_valid;
  logic                     in_ready;
  logic [ROWS*DATA_W-1:0]   in_act;
  logic [ROWS*DATA_W-1:0]   out_act;
  logic [ROWS-1:0]          out_valid_row;
  logic                     busy;
  logic                     done;

  modport master (
    output start, num_vec, weight_busy, in_valid, in_act,
    input  in_ready, out_act, out_valid_row, busy, done
  );

  modport slave (
    input  start, num_vec, weight_busy, in_valid, in_act,
    output in_ready, out_act, out_valid_row, busy, done
  );
endinterface

// File: rtl/act_skew_feeder.sv
// Streams one tile of activation vectors into the systolic array's left edge,
// delaying row i by i cycles, then drains the skew and pulses done.
module act_skew_feeder #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  act_skew_feeder_if.slave   bus,
  output logic [1:0]         o_dbg_state
);

  localparam int DC_W = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(ROWS - 1);
  localparam logic [DC_W-1:0] DC_PRE  = DC_W'(ROWS - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_vec_cnt;
  logic [CNT_W-1:0]   r_num_vec;
  logic [DC_W-1:0]    r_drain_cnt;
  logic               r_done;

  logic               w_hs;
  logic               w_last;
  logic [ROWS*DATA_W-1:0] w_out_act;
  logic [ROWS-1:0]    w_out_vld;

  assign w_hs   = bus.in_valid && (r_state == STREAM);
  assign w_last = (r_vec_cnt == (r_num_vec - CNT_W'(1)));

  // done is registered one cycle early so it lands with drain_cnt == ROWS-1,
  // the same cycle the last vector's bottom-row element reaches out_act.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_vec_cnt   <= '0;
      r_num_vec   <= '0;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.weight_busy) begin
            if (bus.num_vec != '0) begin
              r_num_vec <= bus.num_vec;
              r_vec_cnt <= '0;
              r_state   <= STREAM;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (w_hs) begin
            r_vec_cnt <= r_vec_cnt + CNT_W'(1);
            if (w_last) begin
              r_drain_cnt <= '0;
              r_state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          r_drain_cnt <= r_drain_cnt + DC_W'(1);
          if (r_drain_cnt == DC_PRE) begin
            r_done <= 1'b1;
          end
          if (r_drain_cnt == DC_LAST) begin
            r_drain_cnt <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Row r is a chain of r+1 {valid, data} stages; cycles without a handshake
  // inject exact zeros so the array is never stalled.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    logic [DATA_W-1:0] r_data [gr+1];
    logic              r_vld  [gr+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s <= gr; s++) begin
          r_data[s] <= '0;
          r_vld[s]  <= 1'b0;
        end
      end else begin
        r_data[0] <= w_hs ? bus.in_act[gr*DATA_W +: DATA_W] : '0;
        r_vld[0]  <= w_hs;
        for (int s = 1; s <= gr; s++) begin
          r_data[s] <= r_data[s-1];
          r_vld[s]  <= r_vld[s-1];
        end
      end
    end

    assign w_out_act[gr*DATA_W +: DATA_W] = r_data[gr];
    assign w_out_vld[gr]                  = r_vld[gr];
  end

  assign bus.out_act       = w_out_act;
  assign bus.out_valid_row = w_out_vld;
  assign bus.in_ready      = (r_state == STREAM);
  assign bus.busy          = (r_state != IDLE);
  assign bus.done          = r_done;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder: per-cycle expected outputs are hand-computed
// tables pushed into an expected queue and compared one entry per clock.
module tb_act_skew_feeder;

  localparam int DATA_W = 8;
  localparam int ROWS   = 4;
  localparam int CNT_W  = 16;
  localparam int W      = 3 + ROWS + ROWS*DATA_W;   // {busy, in_ready, done, valid, act}

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;

  act_skew_feeder_if #(.DATA_W(DATA_W), .ROWS(ROWS), .CNT_W(CNT_W)) bus ();

  act_skew_feeder #(.DATA_W(DATA_W), .ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  logic                   drv_v [32];
  logic [ROWS*DATA_W-1:0] drv_d [32];
  logic                   drv_s [32];
  logic [CNT_W-1:0]       drv_n [32];
  logic                   drv_r [32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_drv();
    for (int i = 0; i < 32; i++) begin
      drv_v[i] = 1'b0;
      drv_d[i] = '0;
      drv_s[i] = 1'b0;
      drv_n[i] = '0;
      drv_r[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic push_exp(input logic [2:0] brd, input logic [3:0] vld, input logic [31:0] act);
    exp_q.push_back({brd, vld, act});
  endtask

  // Start is presented in the cycle before slot 0; slot k is cycle c0+k.
  task automatic run_tile(input string name, input logic [CNT_W-1:0] nv);
    logic [W-1:0] e;
    int k;
    bus.start    = 1'b1;
    bus.num_vec  = nv;
    bus.in_valid = drv_v[0];
    bus.in_act   = drv_d[0];
    tick();
    k = 0;
    while (exp_q.size() > 0 && k < 32) begin
      bus.start    = drv_s[k];
      bus.num_vec  = drv_n[k];
      bus.in_valid = drv_v[k];
      bus.in_act   = drv_d[k];
      e = exp_q.pop_front();
      check($sformatf("%s k%0d act", name, k),   64'(bus.out_act),       64'(e[31:0]));
      check($sformatf("%s k%0d vld", name, k),   64'(bus.out_valid_row), 64'(e[35:32]));
      check($sformatf("%s k%0d done", name, k),  64'(bus.done),          64'(e[36]));
      check($sformatf("%s k%0d ready", name, k), 64'(bus.in_ready),      64'(e[37]));
      check($sformatf("%s k%0d busy", name, k),  64'(bus.busy),          64'(e[38]));
      rst = drv_r[k];
      tick();
      k++;
    end
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_act   = '0;
  endtask

  task automatic setup_basic();
    clear_drv();
    drv_v[0] = 1'b1; drv_d[0] = 32'h04030201;
    drv_v[1] = 1'b1; drv_d[1] = 32'h08070605;
    drv_v[2] = 1'b1; drv_d[2] = 32'h0C0B0A09;
  endtask

  task automatic push_basic();
    push_exp(3'b110, 4'b0000, 32'h00000000);
    push_exp(3'b110, 4'b0001, 32'h00000001);
    push_exp(3'b110, 4'b0011, 32'h00000205);
    push_exp(3'b100, 4'b0111, 32'h00030609);
    push_exp(3'b100, 4'b1110, 32'h04070A00);
    push_exp(3'b100, 4'b1100, 32'h080B0000);
    push_exp(3'b101, 4'b1000, 32'h0C000000);
    push_exp(3'b000, 4'b0000, 32'h00000000);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.num_vec     = '0;
    bus.weight_busy = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_act      = '0;

    // Reset held two cycles
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst out_act", 64'(bus.out_act),       64'd0);
    check("rst vld",     64'(bus.out_valid_row), 64'd0);
    check("rst ready",   64'(bus.in_ready),      64'd0);
    check("rst busy",    64'(bus.busy),          64'd0);
    check("rst done",    64'(bus.done),          64'd0);
    check("rst state",   64'(dbg_state),         64'd0);
    tick();

    // Three back-to-back vectors
    setup_basic();
    push_basic();
    run_tile("t2", 16'd3);
    tick();

    // Bubble after vector 1
    clear_drv();
    drv_v[0] = 1'b1; drv_d[0] = 32'h04030201;
    drv_v[1] = 1'b1; drv_d[1] = 32'h08070605;
    drv_v[2] = 1'b0; drv_d[2] = 32'hDEADBEEF;
    drv_v[3] = 1'b1; drv_d[3] = 32'h0C0B0A09;
    push_exp(3'b110, 4'b0000, 32'h00000000);
    push_exp(3'b110, 4'b0001, 32'h00000001);
    push_exp(3'b110, 4'b0011, 32'h00000205);
    push_exp(3'b110, 4'b0110, 32'h00030600);
    push_exp(3'b100, 4'b1101, 32'h04070009);
    push_exp(3'b100, 4'b1010, 32'h08000A00);
    push_exp(3'b100, 4'b0100, 32'h000B0000);
    push_exp(3'b101, 4'b1000, 32'h0C000000);
    push_exp(3'b000, 4'b0000, 32'h00000000);
    run_tile("t3", 16'd3);
    tick();

    // num_vec == 0: done one cycle later, never busy
    bus.start   = 1'b1;
    bus.num_vec = '0;
    check("t4 done pre", 64'(bus.done), 64'd0);
    tick();
    bus.start = 1'b0;
    check("t4 done",  64'(bus.done),     64'd1);
    check("t4 busy",  64'(bus.busy),     64'd0);
    check("t4 ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("t4 done post", 64'(bus.done), 64'd0);
    check("t4 state",     64'(dbg_state), 64'd0);
    tick();

    // start blocked by weight_busy
    bus.weight_busy = 1'b1;
    bus.start       = 1'b1;
    bus.num_vec     = 16'd3;
    tick();
    check("t5a busy",  64'(bus.busy),     64'd0);
    check("t5a ready", 64'(bus.in_ready), 64'd0);
    check("t5a done",  64'(bus.done),     64'd0);
    tick();
    bus.start       = 1'b0;
    bus.weight_busy = 1'b0;
    check("t5a busy2", 64'(bus.busy), 64'd0);
    tick();

    // Second start mid-STREAM has no effect on the tile
    setup_basic();
    drv_s[1] = 1'b1;
    drv_n[1] = 16'd5;
    push_basic();
    run_tile("t5b", 16'd3);
    tick();

    // Reset during the second DRAIN cycle
    setup_basic();
    drv_r[4] = 1'b1;
    push_exp(3'b110, 4'b0000, 32'h00000000);
    push_exp(3'b110, 4'b0001, 32'h00000001);
    push_exp(3'b110, 4'b0011, 32'h00000205);
    push_exp(3'b100, 4'b0111, 32'h00030609);
    push_exp(3'b100, 4'b1110, 32'h04070A00);
    push_exp(3'b000, 4'b0000, 32'h00000000);
    push_exp(3'b000, 4'b0000, 32'h00000000);
    push_exp(3'b000, 4'b0000, 32'h00000000);
    push_exp(3'b000, 4'b0000, 32'h00000000);
    run_tile("t6", 16'd3);
    check("t6 state", 64'(dbg_state), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
